m_mem_access: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline. It consumes the M-stage pipeline register outputs and drives a request/acknowledge handshake to data memory with arbitrary wait states. It produces byte enables and store data, and aligns and extends load data. It stalls the front of the pipeline while a memory access is outstanding and registers the W-stage values (PC, write-back data, destination, Tnew).

---
 rtl/m_mem_access.sv | 210 +++++++++++++++++++++
 tb/tb_m_mem_access.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/m_mem_access.sv
// m_mem_access: MIPS M stage with a req/ack data-memory handshake, store lane steering,
// load alignment and the W-stage register. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses.
module m_mem_access #(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] M_PC_i,
    input  logic [31:0] M_ALUout_i,
    input  logic [31:0] M_HI_i,
    input  logic [31:0] M_LO_i,
    input  logic [3:0]  M_MemOp_i,
    input  logic [31:0] M_rtValue_i,
    input  logic        M_RegWrite_i,
    input  logic [4:0]  M_RegA3_i,
    input  logic [3:0]  M_RegWDsel_i,
    input  logic [2:0]  TnewM_i,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        M_stall_o,
    output logic [31:0] W_PC_o,
    output logic [31:0] W_RegWD_o,
    output logic        W_RegWrite_o,
    output logic [4:0]  W_RegA3_o,
    output logic [2:0]  TnewW_o,
    output logic        W_BusErr_o
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Last WAIT cycle index; in that cycle the request is withdrawn instead of stalling again.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] w_pc_q, w_pc_d;
    logic [31:0] w_wd_q, w_wd_d;
    logic        w_rw_q, w_rw_d;
    logic [4:0]  w_a3_q, w_a3_d;
    logic [2:0]  w_tnew_q, w_tnew_d;
    logic        w_err_q, w_err_d;

    logic        is_load, is_store, is_mem;
    logic        misalign, tmo_hit, abort, req;
    logic [1:0]  lane;
    logic [3:0]  be_raw;
    logic [31:0] wdata_raw, load_data, wd_sel;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign lane = M_ALUout_i[1:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        case (M_MemOp_i)
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: is_load  = 1'b1;
            OP_SW, OP_SH, OP_SB:                 is_store = 1'b1;
            default: begin
                is_load  = 1'b0;
                is_store = 1'b0;
            end
        endcase
    end

    assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (M_MemOp_i)
            OP_LW, OP_SW:         misalign = (lane != 2'b00);
            OP_LH, OP_LHU, OP_SH: misalign = lane[0];
            default:              misalign = 1'b0;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Loads report the lanes they read; stores replicate the source across the word.
    always_comb begin
        be_raw    = 4'b0000;
        wdata_raw = 32'h0;
        case (M_MemOp_i)
            OP_LW, OP_SW:         be_raw = 4'b1111;
            OP_LH, OP_LHU, OP_SH: be_raw = lane[1] ? 4'b1100 : 4'b0011;
            OP_LB, OP_LBU, OP_SB: be_raw = 4'b0001 << lane;
            default:              be_raw = 4'b0000;
        endcase
        case (M_MemOp_i)
            OP_SW:   wdata_raw = M_rtValue_i;
            OP_SH:   wdata_raw = {2{M_rtValue_i[15:0]}};
            OP_SB:   wdata_raw = {4{M_rtValue_i[7:0]}};
            default: wdata_raw = 32'h0;
        endcase
    end

    // M inputs are frozen while stalled, so driving the bus from them keeps it stable in WAIT.
    assign tmo_hit   = (state_q == S_WAIT) && (cnt_q == TMO_LAST);
    assign req       = reset & is_mem & ~misalign & ~tmo_hit;
    assign abort     = tmo_hit | misalign;
    assign dm_req    = req;
    assign dm_we     = req & is_store;
    assign dm_addr   = req ? {M_ALUout_i[31:2], 2'b00} : 32'h0;
    assign dm_be     = req ? be_raw : 4'b0000;
    assign dm_wdata  = dm_we ? wdata_raw : 32'h0;
    assign M_stall_o = req & ~dm_ack;

    always_comb begin
        state_d = state_q;
        cnt_d   = 8'd0;
        case (state_q)
            S_IDLE: begin
                if (M_stall_o) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!M_stall_o) state_d = S_IDLE;
                else            cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_byte = 8'(dm_rdata >> {lane, 3'b000});
        ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (M_MemOp_i)
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'h0, ld_half};
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'h0, ld_byte};
            default: load_data = dm_rdata;
        endcase
    end

    always_comb begin
        case (M_RegWDsel_i)
            4'd0:    wd_sel = M_ALUout_i;
            4'd1:    wd_sel = load_data;
            4'd2:    wd_sel = M_PC_i + 32'd8;
            4'd3:    wd_sel = M_HI_i;
            4'd4:    wd_sel = M_LO_i;
            default: wd_sel = 32'h0;
        endcase
    end

    // A stall sends a bubble to W; an abandoned or trapped access keeps its slot but cannot write.
    always_comb begin
        w_pc_d   = M_PC_i;
        w_wd_d   = wd_sel;
        w_rw_d   = M_RegWrite_i & ~abort;
        w_a3_d   = M_RegA3_i;
        w_tnew_d = (TnewM_i != 3'd0) ? TnewM_i - 3'd1 : 3'd0;
        w_err_d  = abort;
        if (M_stall_o) begin
            w_wd_d   = 32'h0;
            w_rw_d   = 1'b0;
            w_a3_d   = 5'd0;
            w_tnew_d = 3'd0;
            w_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            w_pc_q   <= RESET_PC;
            w_wd_q   <= 32'h0;
            w_rw_q   <= 1'b0;
            w_a3_q   <= 5'd0;
            w_tnew_q <= 3'd0;
            w_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            w_pc_q   <= w_pc_d;
            w_wd_q   <= w_wd_d;
            w_rw_q   <= w_rw_d;
            w_a3_q   <= w_a3_d;
            w_tnew_q <= w_tnew_d;
            w_err_q  <= w_err_d;
        end
    end

    assign W_PC_o       = w_pc_q;
    assign W_RegWD_o    = w_wd_q;
    assign W_RegWrite_o = w_rw_q;
    assign W_RegA3_o    = w_a3_q;
    assign TnewW_o      = w_tnew_q;
    assign W_BusErr_o   = w_err_q;

endmodule

// File: tb/tb_m_mem_access.sv
// Scoreboard bench for m_mem_access: the driver queues the expected W contents per instruction,
// a monitor pops and compares whenever an instruction leaves M.
module tb_m_mem_access;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] M_PC_i, M_ALUout_i, M_HI_i, M_LO_i, M_rtValue_i;
    logic [3:0]  M_MemOp_i, M_RegWDsel_i;
    logic        M_RegWrite_i;
    logic [4:0]  M_RegA3_i;
    logic [2:0]  TnewM_i;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        M_stall_o;
    logic [31:0] W_PC_o, W_RegWD_o;
    logic        W_RegWrite_o;
    logic [4:0]  W_RegA3_o;
    logic [2:0]  TnewW_o;
    logic        W_BusErr_o;

    logic m_valid;
    int   n_tests = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] wd;
        logic        rw;
        logic [4:0]  a3;
        logic [2:0]  tnew;
        logic        err;
    } wexp_t;

    wexp_t exp_q[$];

    m_mem_access #(.TIMEOUT(TMO), .RESET_PC(32'h0000_3000)) dut (
        .clk(clk), .reset(reset),
        .M_PC_i(M_PC_i), .M_ALUout_i(M_ALUout_i), .M_HI_i(M_HI_i), .M_LO_i(M_LO_i),
        .M_MemOp_i(M_MemOp_i), .M_rtValue_i(M_rtValue_i), .M_RegWrite_i(M_RegWrite_i),
        .M_RegA3_i(M_RegA3_i), .M_RegWDsel_i(M_RegWDsel_i), .TnewM_i(TnewM_i),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata), .M_stall_o(M_stall_o),
        .W_PC_o(W_PC_o), .W_RegWD_o(W_RegWD_o), .W_RegWrite_o(W_RegWrite_o),
        .W_RegA3_o(W_RegA3_o), .TnewW_o(TnewW_o), .W_BusErr_o(W_BusErr_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Pops one entry per instruction leaving M; stalled cycles must have put a bubble into W.
    initial begin : monitor
        logic  cv, cs;
        wexp_t e;
        forever begin
            @(negedge clk);
            #2;
            cv = m_valid;
            cs = M_stall_o;
            @(posedge clk);
            #1;
            if (cv) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: W updated with no expected entry");
                end else if (cs) begin
                    check("bubble_pc",   W_PC_o,              exp_q[0].pc);
                    check("bubble_rw",   32'(W_RegWrite_o),   32'd0);
                    check("bubble_a3",   32'(W_RegA3_o),      32'd0);
                    check("bubble_tnew", 32'(TnewW_o),        32'd0);
                    check("bubble_err",  32'(W_BusErr_o),     32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("w_pc",   W_PC_o,            e.pc);
                    check("w_wd",   W_RegWD_o,         e.wd);
                    check("w_rw",   32'(W_RegWrite_o), 32'(e.rw));
                    check("w_a3",   32'(W_RegA3_o),    32'(e.a3));
                    check("w_tnew", 32'(TnewW_o),      32'(e.tnew));
                    check("w_err",  32'(W_BusErr_o),   32'(e.err));
                end
            end
        end
    end

    // dly: cycle index (0 = request cycle) in which ack is raised; negative means never.
    task automatic issue(
        input logic [31:0] pc, input logic [3:0] op, input logic [31:0] alu, input logic [31:0] rt,
        input logic [31:0] hi, input logic [31:0] lo, input logic [31:0] rdata,
        input logic rw, input logic [4:0] a3, input logic [3:0] sel, input logic [2:0] tnew,
        input int dly, input logic e_req, input logic e_we, input logic [3:0] e_be,
        input logic [31:0] e_wdata, input int e_stalls,
        input logic [31:0] w_wd, input logic w_rw, input logic [2:0] w_tnew, input logic w_err);
        wexp_t e;
        int    stalls;
        bit    ended;
        logic  req_now;
        @(negedge clk);
        M_PC_i = pc; M_MemOp_i = op; M_ALUout_i = alu; M_rtValue_i = rt;
        M_HI_i = hi; M_LO_i = lo; dm_rdata = rdata; M_RegWrite_i = rw;
        M_RegA3_i = a3; M_RegWDsel_i = sel; TnewM_i = tnew;
        dm_ack = (dly == 0);
        m_valid = 1'b1;
        e.pc = pc; e.wd = w_wd; e.rw = w_rw; e.a3 = a3; e.tnew = w_tnew; e.err = w_err;
        exp_q.push_back(e);
        stalls = 0;
        ended  = 1'b0;
        for (int k = 0; k < 20 && !ended; k++) begin
            #1;
            req_now = e_req && !(dly < 0 && k == e_stalls);
            check("dm_req", 32'(dm_req), 32'(req_now));
            if (req_now) begin
                check("dm_we",    32'(dm_we), 32'(e_we));
                check("dm_be",    32'(dm_be), 32'(e_be));
                check("dm_addr",  dm_addr,    {alu[31:2], 2'b00});
                check("dm_wdata", dm_wdata,   e_wdata);
            end
            if (M_stall_o) stalls++;
            else           ended = 1'b1;
            if (!ended) begin
                @(negedge clk);
                dm_ack = (k + 1 == dly);
            end
        end
        if (!ended) begin
            n_tests++;
            n_fail++;
            $display("FAIL stall_bound: stall still high after 20 cycles at pc 0x%08h", pc);
        end
        check("stall_cycles", 32'(stalls), 32'(e_stalls));
    endtask

    task automatic idle();
        @(negedge clk);
        m_valid = 1'b0; M_MemOp_i = 4'd0; M_RegWrite_i = 1'b0; dm_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0; m_valid = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
        M_PC_i = 32'h0; M_ALUout_i = 32'h10; M_HI_i = 32'h0; M_LO_i = 32'h0;
        M_MemOp_i = 4'd6; M_rtValue_i = 32'hFFFF_FFFF; M_RegWrite_i = 1'b1;
        M_RegA3_i = 5'd3; M_RegWDsel_i = 4'd0; TnewM_i = 3'd2;
        #12;
        check("rst_w_pc",   W_PC_o,            32'h0000_3000);
        check("rst_w_wd",   W_RegWD_o,         32'h0);
        check("rst_w_rw",   32'(W_RegWrite_o), 32'd0);
        check("rst_w_a3",   32'(W_RegA3_o),    32'd0);
        check("rst_tnew",   32'(TnewW_o),      32'd0);
        check("rst_buserr", 32'(W_BusErr_o),   32'd0);
        check("rst_req",    32'(dm_req),       32'd0);
        check("rst_we",     32'(dm_we),        32'd0);
        check("rst_be",     32'(dm_be),        32'd0);
        check("rst_wdata",  dm_wdata,          32'h0);
        check("rst_stall",  32'(M_stall_o),    32'd0);
        @(negedge clk);
        reset = 1'b1; M_MemOp_i = 4'd0; M_RegWrite_i = 1'b0;

        //     pc            op    alu           rt            hi       lo          rdata         rw    a3     sel   tnew  dly req we  be       wdata         st  w_wd          w_rw  w_tn  err
        issue(32'h400, 4'd1, 32'h10, 32'hDEAD_BEEF, 32'h0, 32'h0,      32'h1234_5678, 1'b1, 5'd5,  4'd1, 3'd1, 0,  1, 0, 4'b1111, 32'h0,         0, 32'h1234_5678, 1'b1, 3'd0, 1'b0);
        issue(32'h404, 4'd4, 32'h13, 32'hDEAD_BEEF, 32'h0, 32'h0,      32'h80FF_0000, 1'b1, 5'd6,  4'd1, 3'd1, 3,  1, 0, 4'b1000, 32'h0,         3, 32'hFFFF_FF80, 1'b1, 3'd0, 1'b0);
        issue(32'h408, 4'd7, 32'h2,  32'hAAAA_BEEF, 32'h0, 32'h0,      32'h0,         1'b0, 5'd0,  4'd0, 3'd0, 1,  1, 1, 4'b1100, 32'hBEEF_BEEF, 1, 32'h2,         1'b0, 3'd0, 1'b0);
        issue(32'h40C, 4'd0, 32'h99, 32'h0,         32'h5, 32'h0,      32'h0,         1'b1, 5'd7,  4'd3, 3'd2, 0,  0, 0, 4'b0000, 32'h0,         0, 32'h5,         1'b1, 3'd1, 1'b0);
        issue(32'h410, 4'd1, 32'h20, 32'h0,         32'h0, 32'h0,      32'hFFFF_FFFF, 1'b1, 5'd8,  4'd0, 3'd1, -1, 1, 0, 4'b1111, 32'h0,       TMO, 32'h20,        1'b0, 3'd0, 1'b1);
        issue(32'h414, 4'd8, 32'h21, 32'h1234_5678, 32'h0, 32'h0,      32'h0,         1'b0, 5'd0,  4'd2, 3'd0, 0,  1, 1, 4'b0010, 32'h7878_7878, 0, 32'h41C,       1'b0, 3'd0, 1'b0);
        issue(32'h418, 4'd3, 32'h6,  32'h0,         32'h0, 32'h0,      32'h8001_7FFF, 1'b1, 5'd9,  4'd1, 3'd2, 2,  1, 0, 4'b1100, 32'h0,         2, 32'h0000_8001, 1'b1, 3'd1, 1'b0);
        issue(32'h41C, 4'd2, 32'h4,  32'h0,         32'h0, 32'h0,      32'h1234_8765, 1'b1, 5'd10, 4'd1, 3'd1, 0,  1, 0, 4'b0011, 32'h0,         0, 32'hFFFF_8765, 1'b1, 3'd0, 1'b0);
        issue(32'h420, 4'd5, 32'h11, 32'h0,         32'h0, 32'h0,      32'h0000_C300, 1'b1, 5'd11, 4'd1, 3'd1, 1,  1, 0, 4'b0010, 32'h0,         1, 32'h0000_00C3, 1'b1, 3'd0, 1'b0);
        issue(32'h424, 4'd15, 32'h8, 32'h0,         32'h0, 32'hCAFE,   32'h0,         1'b1, 5'd12, 4'd4, 3'd0, -1, 0, 0, 4'b0000, 32'h0,         0, 32'h0000_CAFE, 1'b1, 3'd0, 1'b0);
        issue(32'h428, 4'd6, 32'h40, 32'h0BAD_F00D, 32'h0, 32'h0,      32'h0,         1'b0, 5'd0,  4'd5, 3'd0, 0,  1, 1, 4'b1111, 32'h0BAD_F00D, 0, 32'h0,         1'b0, 3'd0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        issue(32'h42C, 4'd1, 32'h1,  32'h0,         32'h0, 32'h0,      32'h1122_3344, 1'b1, 5'd13, 4'd1, 3'd1, 0,  0, 0, 4'b0000, 32'h0,         0, 32'h1122_3344, 1'b0, 3'd0, 1'b1);
`else
        issue(32'h42C, 4'd1, 32'h1,  32'h0,         32'h0, 32'h0,      32'h1122_3344, 1'b1, 5'd13, 4'd1, 3'd1, 0,  1, 0, 4'b1111, 32'h0,         0, 32'h1122_3344, 1'b1, 3'd0, 1'b0);
`endif

        // Reset asserted while an access sits in WAIT.
        @(negedge clk);
        m_valid = 1'b0; M_MemOp_i = 4'd1; M_ALUout_i = 32'h50; M_RegWrite_i = 1'b1; dm_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rstw_stall_before", 32'(M_stall_o), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rstw_req",    32'(dm_req),       32'd0);
        check("rstw_be",     32'(dm_be),        32'd0);
        check("rstw_addr",   dm_addr,           32'h0);
        check("rstw_stall",  32'(M_stall_o),    32'd0);
        check("rstw_w_pc",   W_PC_o,            32'h0000_3000);
        check("rstw_w_rw",   32'(W_RegWrite_o), 32'd0);
        check("rstw_buserr", 32'(W_BusErr_o),   32'd0);
        @(negedge clk);
        reset = 1'b1; M_MemOp_i = 4'd0; M_RegWrite_i = 1'b0;

        issue(32'h430, 4'd1, 32'h30, 32'h0,         32'h0, 32'h0,      32'h55AA_55AA, 1'b1, 5'd14, 4'd1, 3'd1, 1,  1, 0, 4'b1111, 32'h0,         1, 32'h55AA_55AA, 1'b1, 3'd0, 1'b0);
        idle();
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
